// File: rtl/riffa_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riffa_tx_pkg
// Purpose : Gate FIFO word layout, end-marker value, monitor state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package riffa_tx_pkg;

  // Header fields live in the low 64 payload bits; the flag sits just above the payload.
  localparam int C_FLAG_BIT_DEFAULT = 128;
  localparam int C_LAST_BIT         = 0;
  localparam int C_OFF_LSB          = 1;
  localparam int C_OFF_MSB          = 31;
  localparam int C_LEN_LSB          = 32;
  localparam int C_LEN_MSB          = 63;

  localparam int                    C_MARKER_W   = 128;
  localparam logic [C_MARKER_W-1:0] C_END_MARKER = '0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  function automatic logic [31:0] sat_add4(input logic [31:0] v);
    return (v > 32'hFFFF_FFFB) ? 32'hFFFF_FFFF : v + 32'd4;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_port_out_reg.sv
`default_nettype none
// ============================================================================
// Module  : tx_port_out_reg
// Purpose : Single-entry payload holding register with valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module tx_port_out_reg #(
  parameter int C_DATA_WIDTH = 128
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic [C_DATA_WIDTH-1:0] data_i,
  input  logic                    ready_i,
  output logic [C_DATA_WIDTH-1:0] data_o,
  output logic                    valid_o
);

  logic [C_DATA_WIDTH-1:0] data_q;
  logic                    valid_q;

  // load_i is only raised when the slot is empty or draining this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/tx_port_monitor_128.sv
`default_nettype none
// ============================================================================
// Module  : tx_port_monitor_128
// Purpose : Decodes gate FIFO words into transaction header/payload/done events.
//           Optional TX_PORT_MONITOR_STATS_EN adds STAT_TXNS / STAT_DROPS.
// Revision: 1.0 - initial release
// ============================================================================
module tx_port_monitor_128
  import riffa_tx_pkg::*;
#(
  parameter int C_DATA_WIDTH      = 128,
  parameter int C_FIFO_DATA_WIDTH = C_DATA_WIDTH + 1
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [C_FIFO_DATA_WIDTH-1:0] RD_DATA,
  input  logic                         RD_EMPTY,
  output logic                         RD_EN,
  output logic                         TXN,
  output logic [31:0]                  TXN_LEN,
  output logic [30:0]                  TXN_OFF,
  output logic                         TXN_LAST,
  output logic [C_DATA_WIDTH-1:0]      OUT_DATA,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
`ifdef TX_PORT_MONITOR_STATS_EN
  output logic [31:0]                  STAT_TXNS,
  output logic [31:0]                  STAT_DROPS,
`endif
  output logic                         DONE,
  output logic [31:0]                  DONE_WORDS
);

  state_t      state_q;
  logic        txn_q;
  logic        done_q;
  logic [31:0] done_words_q;
  logic [31:0] len_q;
  logic [30:0] off_q;
  logic        last_q;
  logic [31:0] cnt_q;

  logic                    flag_d;
  logic [C_DATA_WIDTH-1:0] payload_d;
  logic                    is_data_d;
  logic                    is_hdr_d;
  logic                    load_d;

  assign flag_d    = RD_DATA[C_DATA_WIDTH];
  assign payload_d = RD_DATA[C_DATA_WIDTH-1:0];
  assign is_data_d = !flag_d;
  assign is_hdr_d  = flag_d && (payload_d != C_DATA_WIDTH'(C_END_MARKER));

  // Holding off pops while in reset keeps queued words for after release.
  assign RD_EN  = RST_N && !RD_EMPTY && (!OUT_VALID || OUT_READY);
  assign load_d = RD_EN && is_data_d && (state_q == ST_DATA);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      txn_q        <= 1'b0;
      done_q       <= 1'b0;
      done_words_q <= '0;
      len_q        <= '0;
      off_q        <= '0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      txn_q  <= 1'b0;
      done_q <= 1'b0;
      if (RD_EN) begin
        case (state_q)
          ST_IDLE: begin
            if (is_hdr_d) begin
              txn_q   <= 1'b1;
              len_q   <= payload_d[C_LEN_MSB:C_LEN_LSB];
              off_q   <= payload_d[C_OFF_MSB:C_OFF_LSB];
              last_q  <= payload_d[C_LAST_BIT];
              cnt_q   <= '0;
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (is_data_d) begin
              cnt_q <= sat_add4(cnt_q);
            end else begin
              done_q       <= 1'b1;
              done_words_q <= cnt_q;
              cnt_q        <= '0;
              // A header here closes the current transfer and opens the next one.
              if (is_hdr_d) begin
                txn_q  <= 1'b1;
                len_q  <= payload_d[C_LEN_MSB:C_LEN_LSB];
                off_q  <= payload_d[C_OFF_MSB:C_OFF_LSB];
                last_q <= payload_d[C_LAST_BIT];
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  tx_port_out_reg #(
    .C_DATA_WIDTH(C_DATA_WIDTH)
  ) u_out_reg (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .load_i (load_d),
    .data_i (payload_d),
    .ready_i(OUT_READY),
    .data_o (OUT_DATA),
    .valid_o(OUT_VALID)
  );

`ifdef TX_PORT_MONITOR_STATS_EN
  logic [31:0] stat_txns_q;
  logic [31:0] stat_drops_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stat_txns_q  <= '0;
      stat_drops_q <= '0;
    end else begin
      if (RD_EN && is_hdr_d) begin
        stat_txns_q <= sat_inc(stat_txns_q);
      end
      if (RD_EN && is_data_d && (state_q == ST_IDLE)) begin
        stat_drops_q <= sat_inc(stat_drops_q);
      end
    end
  end

  assign STAT_TXNS  = stat_txns_q;
  assign STAT_DROPS = stat_drops_q;
`endif

  assign TXN        = txn_q;
  assign TXN_LEN    = len_q;
  assign TXN_OFF    = off_q;
  assign TXN_LAST   = last_q;
  assign DONE       = done_q;
  assign DONE_WORDS = done_words_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_port_monitor_128.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_tx_port_monitor_128
// Purpose : Directed bench with a transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tx_port_monitor_128;

  localparam int DW = 128;
  localparam int FW = DW + 1;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [FW-1:0] RD_DATA;
  logic          RD_EMPTY;
  logic          RD_EN;
  logic          TXN;
  logic [31:0]   TXN_LEN;
  logic [30:0]   TXN_OFF;
  logic          TXN_LAST;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic          DONE;
  logic [31:0]   DONE_WORDS;
`ifdef TX_PORT_MONITOR_STATS_EN
  logic [31:0]   STAT_TXNS;
  logic [31:0]   STAT_DROPS;
`endif

  tx_port_monitor_128 #(.C_DATA_WIDTH(DW), .C_FIFO_DATA_WIDTH(FW)) dut (
    .CLK(CLK), .RST_N(RST_N), .RD_DATA(RD_DATA), .RD_EMPTY(RD_EMPTY), .RD_EN(RD_EN),
    .TXN(TXN), .TXN_LEN(TXN_LEN), .TXN_OFF(TXN_OFF), .TXN_LAST(TXN_LAST),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
`ifdef TX_PORT_MONITOR_STATS_EN
    .STAT_TXNS(STAT_TXNS), .STAT_DROPS(STAT_DROPS),
`endif
    .DONE(DONE), .DONE_WORDS(DONE_WORDS)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [FW-1:0] fifo[$];

  // Reference model state: one open transfer or none, plus output slot.
  bit            m_busy, m_vld, m_txn, m_done, m_last;
  logic [DW-1:0] m_data;
  longint        m_cnt, m_dw;
  logic [31:0]   m_len;
  logic [30:0]   m_off;
  int            m_txns, m_drops;

  // Observations of the DUT, zeroed by each scenario.
  int          o_txn, o_done, o_both, o_beats, o_stall_rden, o_beats_at_done;
  logic [31:0] o_len, o_dw, o_dw_first;
  logic [30:0] o_off;
  logic        o_last;

  localparam logic [FW-1:0] ENDM = {1'b1, {DW{1'b0}}};

  function automatic logic [FW-1:0] hdr(input logic [31:0] len, input logic [30:0] off, input logic last);
    return {1'b1, 64'd0, len, off, last};
  endfunction

  function automatic logic [FW-1:0] dat(input logic [DW-1:0] x);
    return {1'b0, x};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic refresh();
    RD_EMPTY = (fifo.size() == 0);
    RD_DATA  = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  function automatic bit m_rd_en();
    return RST_N && (fifo.size() != 0) && (!m_vld || OUT_READY);
  endfunction

  task automatic model_clear();
    m_busy = 0; m_vld = 0; m_txn = 0; m_done = 0; m_last = 0;
    m_data = '0; m_cnt = 0; m_dw = 0; m_len = '0; m_off = '0;
    m_txns = 0; m_drops = 0;
  endtask

  task automatic model_step();
    bit            p;
    logic [FW-1:0] w;
    p = m_rd_en();
    w = RD_DATA;
    m_txn = 0;
    m_done = 0;
    if (m_vld && OUT_READY) m_vld = 0;
    if (p) begin
      if (!w[DW]) begin
        if (m_busy) begin
          m_vld  = 1;
          m_data = w[DW-1:0];
          m_cnt  = (m_cnt + 4 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 4;
        end else begin
          m_drops++;
        end
      end else if (w[DW-1:0] == '0) begin
        if (m_busy) begin
          m_done = 1; m_dw = m_cnt; m_busy = 0;
        end
      end else begin
        if (m_busy) begin
          m_done = 1; m_dw = m_cnt;
        end
        m_txn = 1; m_len = w[63:32]; m_off = w[31:1]; m_last = w[0];
        m_cnt = 0; m_busy = 1; m_txns++;
      end
    end
  endtask

  task automatic compare();
    chk("rd_en", RD_EN, m_rd_en());
    chk("txn", TXN, m_txn);
    chk("done", DONE, m_done);
    chk("out_valid", OUT_VALID, m_vld);
    if (m_vld) chk("out_data", OUT_DATA, m_data);
    chk("done_words", DONE_WORDS, m_dw[31:0]);
    chk("txn_len", TXN_LEN, m_len);
    chk("txn_off", TXN_OFF, m_off);
    chk("txn_last", TXN_LAST, m_last);
`ifdef TX_PORT_MONITOR_STATS_EN
    chk("stat_txns", STAT_TXNS, m_txns);
    chk("stat_drops", STAT_DROPS, m_drops);
`endif
    if (TXN) begin
      o_txn++; o_len = TXN_LEN; o_off = TXN_OFF; o_last = TXN_LAST;
    end
    if (DONE) begin
      if (o_done == 0) o_dw_first = DONE_WORDS;
      o_done++; o_dw = DONE_WORDS; o_beats_at_done = o_beats;
    end
    if (TXN && DONE) o_both++;
    if (OUT_VALID && OUT_READY) o_beats++;
    if (OUT_VALID && !OUT_READY && RD_EN) o_stall_rden++;
  endtask

  // Entered at a falling edge; model advances just before the rising edge.
  task automatic tick();
    bit pop;
    #4;
    pop = RD_EN;
    if (!RST_N) model_clear();
    else model_step();
    @(posedge CLK);
    #1;
    if (pop && fifo.size() != 0) void'(fifo.pop_front());
    refresh();
    @(negedge CLK);
    if (RST_N) compare();
  endtask

  task automatic clear_obs();
    o_txn = 0; o_done = 0; o_both = 0; o_beats = 0; o_stall_rden = 0; o_beats_at_done = 0;
    o_len = '0; o_dw = '0; o_dw_first = '0; o_off = '0; o_last = 0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 200; i++) begin
      tick();
      if (fifo.size() == 0 && !OUT_VALID) break;
    end
    chk("drain_timeout", (i < 200), 1'b1);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    fifo.delete();
    fifo.push_back(dat(128'h1));
    refresh();
    model_clear();
    repeat (2) tick();
    chk("rst_rd_en", RD_EN, 1'b0);
    fifo.delete();
    refresh();
    RST_N = 1'b1;
    clear_obs();
  endtask

  localparam logic [DW-1:0] D0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DW-1:0] D1 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

  initial begin
    logic [DW-1:0] held;
    int            k;
    RST_N = 1'b0;
    OUT_READY = 1'b1;
    fifo.delete();
    refresh();
    model_clear();
    clear_obs();
    @(negedge CLK);

    do_reset();
    chk("reset_txn", TXN, 1'b0);
    chk("reset_done", DONE, 1'b0);
    chk("reset_out_valid", OUT_VALID, 1'b0);
    chk("reset_done_words", DONE_WORDS, 32'd0);
    chk("reset_txn_len", TXN_LEN, 32'd0);

    // Basic transfer with duplicated end marker.
    fifo.push_back(hdr(32'd8, 31'd0, 1'b1));
    fifo.push_back(dat(D0));
    fifo.push_back(dat(D1));
    fifo.push_back(ENDM);
    fifo.push_back(ENDM);
    refresh();
    drain();
    chk("s1_txn_count", o_txn, 1);
    chk("s1_txn_len", o_len, 32'd8);
    chk("s1_txn_off", o_off, 31'd0);
    chk("s1_txn_last", o_last, 1'b1);
    chk("s1_beats", o_beats, 2);
    chk("s1_done_count", o_done, 1);
    chk("s1_done_words", o_dw, 32'd8);

    // Backpressure: first beat held five cycles.
    clear_obs();
    fifo.push_back(hdr(32'd8, 31'd0, 1'b1));
    fifo.push_back(dat(D0));
    fifo.push_back(dat(D1));
    fifo.push_back(ENDM);
    fifo.push_back(ENDM);
    refresh();
    for (k = 0; k < 50 && !OUT_VALID; k++) tick();
    chk("s2_first_beat_seen", OUT_VALID, 1'b1);
    OUT_READY = 1'b0;
    held = OUT_DATA;
    repeat (5) tick();
    chk("s2_held_data", OUT_DATA, D0);
    chk("s2_held_stable", OUT_DATA, held);
    chk("s2_rd_en_while_stalled", o_stall_rden, 0);
    chk("s2_done_during_stall", o_done, 0);
    OUT_READY = 1'b1;
    drain();
    chk("s2_beats", o_beats, 2);
    chk("s2_done_count", o_done, 1);
    chk("s2_done_words", o_dw, 32'd8);
    chk("s2_beats_before_done", o_beats_at_done, 2);

    // Empty transfer.
    clear_obs();
    fifo.push_back(hdr(32'd16, 31'd4, 1'b0));
    fifo.push_back(ENDM);
    fifo.push_back(ENDM);
    refresh();
    drain();
    chk("s3_txn_count", o_txn, 1);
    chk("s3_txn_off", o_off, 31'd4);
    chk("s3_done_count", o_done, 1);
    chk("s3_done_words", o_dw, 32'd0);
    chk("s3_beats", o_beats, 0);

    // Back-to-back headers.
    clear_obs();
    fifo.push_back(hdr(32'd12, 31'd0, 1'b0));
    fifo.push_back(dat(D0));
    fifo.push_back(hdr(32'd4, 31'd0, 1'b1));
    fifo.push_back(dat(D1));
    fifo.push_back(ENDM);
    refresh();
    drain();
    chk("s4_same_cycle", o_both, 1);
    chk("s4_txn_count", o_txn, 2);
    chk("s4_done_count", o_done, 2);
    chk("s4_first_done_words", o_dw_first, 32'd4);
    chk("s4_last_done_words", o_dw, 32'd4);
    chk("s4_txn_b_len", o_len, 32'd4);
    chk("s4_beats", o_beats, 2);

    // Reset mid-transfer.
    clear_obs();
    fifo.push_back(hdr(32'd8, 31'd0, 1'b0));
    fifo.push_back(dat(D0));
    fifo.push_back(dat(D1));
    fifo.push_back(dat(D0));
    refresh();
    for (k = 0; k < 50 && o_beats < 3; k++) tick();
    chk("s5_three_beats", o_beats, 3);
    RST_N = 1'b0;
    #1;
    chk("s5_async_out_valid", OUT_VALID, 1'b0);
    chk("s5_async_txn_len", TXN_LEN, 32'd0);
    chk("s5_async_done_words", DONE_WORDS, 32'd0);
    chk("s5_async_rd_en", RD_EN, 1'b0);
    fifo.delete();
    refresh();
    model_clear();
    @(negedge CLK);
    repeat (2) tick();
    chk("s5_no_done", o_done, 0);
    RST_N = 1'b1;
    clear_obs();
    fifo.push_back(hdr(32'd4, 31'd2, 1'b1));
    fifo.push_back(dat(D1));
    fifo.push_back(ENDM);
    refresh();
    drain();
    chk("s5_txn_count", o_txn, 1);
    chk("s5_txn_off", o_off, 31'd2);
    chk("s5_done_count", o_done, 1);
    chk("s5_done_words", o_dw, 32'd4);

`ifdef TX_PORT_MONITOR_STATS_EN
    do_reset();
    fifo.push_back(dat(D0));
    fifo.push_back(dat(D1));
    fifo.push_back(hdr(32'd4, 31'd0, 1'b0));
    fifo.push_back(dat(D0));
    fifo.push_back(ENDM);
    refresh();
    drain();
    chk("s6_stat_drops", STAT_DROPS, 32'd2);
    chk("s6_stat_txns", STAT_TXNS, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
